// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state type and bit-reverse helper for the
// 1024-point FFT controller.
package fft_pkg;

    localparam int FFT_N     = 1024;
    localparam int FFT_LOG2N = 10;
    localparam int FFT_BFLY  = 512;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_LOAD         = 3'd1,
        ST_COMPUTE      = 3'd2,
        ST_UNLOAD_ADDR  = 3'd3,
        ST_UNLOAD_VALID = 3'd4
    } fft_state_t;

    // Mirror the bits of a 10-bit index (bit 0 <-> bit 9, ...).
    function automatic logic [FFT_LOG2N-1:0] bit_reverse(input logic [FFT_LOG2N-1:0] v);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = v[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_controller_if.sv
// fft_controller_if: sample input / result output handshake bundle.
//
// Handshake rules: a transfer happens on a posedge where valid and ready are
// both 1. The producer holds valid (and its payload) until that edge; ready
// may change freely and never depends combinationally on valid.
//   in_valid / in_ready   : environment -> controller input samples
//   out_valid / out_ready : controller -> consumer results, out_index payload
// start is a level sampled by the controller only while idle.
interface fft_controller_if;
    import fft_pkg::*;

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [FFT_LOG2N-1:0] out_index;

    // Environment side: supplies samples and consumes results.
    modport master (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, out_index
    );

    // Controller side.
    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, out_index
    );

endinterface

// File: rtl/fft_controller.sv
// fft_controller: sequences load, 10-stage compute and bit-reversed unload of
// a 1024-point in-place FFT RAM.
// Optional build macro FFT_CTRL_PERF_EN adds the perfCycles output.
module fft_controller
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fft_controller_if.slave      bus,
    output logic                 externalLoad,
    output logic                 load,
    output logic                 scan,
    output logic [FFT_LOG2N-1:0] externalIndexA,
    output logic [4:0]           stageCount,
    output logic [8:0]           cycleCount,
    output logic                 busy,
    output logic                 done,
    output fft_state_t           dbg_state
`ifdef FFT_CTRL_PERF_EN
    ,
    output logic [15:0]          perfCycles
`endif
);

    localparam logic [FFT_LOG2N-1:0] LAST_IDX   = FFT_LOG2N'(FFT_N - 1);
    localparam logic [8:0]           LAST_CYCLE = 9'(FFT_BFLY - 1);
    localparam logic [4:0]           LAST_STAGE = 5'(FFT_LOG2N - 1);

    fft_state_t           r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_load;
    logic                 r_scan;
    logic                 r_busy;
    logic                 r_done;
    logic [FFT_LOG2N-1:0] r_load_cnt;
    logic [FFT_LOG2N-1:0] r_out_cnt;
    logic [FFT_LOG2N-1:0] r_ext_idx;
    logic [4:0]           r_stage;
    logic [8:0]           r_cycle;

    logic [FFT_LOG2N-1:0] w_load_cnt_nxt;
    logic [FFT_LOG2N-1:0] w_out_cnt_nxt;

    assign w_load_cnt_nxt = r_load_cnt + FFT_LOG2N'(1);
    assign w_out_cnt_nxt  = r_out_cnt + FFT_LOG2N'(1);

    // Main FSM: all outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_load      <= 1'b0;
            r_scan      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_cnt  <= '0;
            r_out_cnt   <= '0;
            r_ext_idx   <= '0;
            r_stage     <= '0;
            r_cycle     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_load_cnt <= '0;
                        r_out_cnt  <= '0;
                        r_ext_idx  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (r_load_cnt == LAST_IDX) begin
                            r_state    <= ST_COMPUTE;
                            r_in_ready <= 1'b0;
                            r_load     <= 1'b1;
                            r_load_cnt <= '0;
                            r_ext_idx  <= '0;
                            r_stage    <= '0;
                            r_cycle    <= '0;
                        end else begin
                            r_load_cnt <= w_load_cnt_nxt;
                            r_ext_idx  <= w_load_cnt_nxt;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_cycle == LAST_CYCLE) begin
                        r_cycle <= '0;
                        if (r_stage == LAST_STAGE) begin
                            // Bin 0 reverses to address 0, so the first unload
                            // address needs no lookup.
                            r_state   <= ST_UNLOAD_ADDR;
                            r_load    <= 1'b0;
                            r_scan    <= 1'b1;
                            r_stage   <= '0;
                            r_out_cnt <= '0;
                            r_ext_idx <= '0;
                        end else begin
                            r_stage <= r_stage + 5'd1;
                        end
                    end else begin
                        r_cycle <= r_cycle + 9'd1;
                    end
                end
                ST_UNLOAD_ADDR: begin
                    // RAM read data appears one cycle after the address.
                    r_state     <= ST_UNLOAD_VALID;
                    r_out_valid <= 1'b1;
                end
                ST_UNLOAD_VALID: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_cnt == LAST_IDX) begin
                            r_state   <= ST_IDLE;
                            r_scan    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_out_cnt <= '0;
                            r_ext_idx <= '0;
                        end else begin
                            r_state   <= ST_UNLOAD_ADDR;
                            r_out_cnt <= w_out_cnt_nxt;
                            r_ext_idx <= bit_reverse(w_out_cnt_nxt);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FFT_CTRL_PERF_EN
    logic [15:0] r_perf;

    // Busy-cycle counter: cleared on start, saturates, holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_perf <= '0;
            end
        end else if (r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perfCycles = r_perf;
`endif

    // Sample writes follow the input handshake directly.
    assign externalLoad   = r_in_ready & bus.in_valid;
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_index  = r_out_cnt;
    assign load           = r_load;
    assign scan           = r_scan;
    assign externalIndexA = r_ext_idx;
    assign stageCount     = r_stage;
    assign cycleCount     = r_cycle;
    assign busy           = r_busy;
    assign done           = r_done;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: randomized bench with a behavioural model of the
// controller's externally visible sequence and a small RAM fixture.
// Build with FFT_CTRL_PERF_EN to also cover perfCycles.
`timescale 1ns/1ps
module tb_fft_controller;
    import fft_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    fft_controller_if bus();
    logic       externalLoad, load, scan, busy, done;
    logic [9:0] externalIndexA;
    logic [4:0] stageCount;
    logic [8:0] cycleCount;
    fft_state_t dbg_state;
`ifdef FFT_CTRL_PERF_EN
    logic [15:0] perfCycles;
`endif

    fft_controller dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .externalLoad   (externalLoad),
        .load           (load),
        .scan           (scan),
        .externalIndexA (externalIndexA),
        .stageCount     (stageCount),
        .cycleCount     (cycleCount),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
`ifdef FFT_CTRL_PERF_EN
        ,
        .perfCycles     (perfCycles)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 10; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // ---------------- RAM fixture ----------------
    logic [15:0] in_data;
    logic [15:0] ram [0:1023];
    logic [15:0] rd_q;

    always @(posedge clk) begin
        if (externalLoad === 1'b1) ram[externalIndexA] <= in_data;
        if (scan === 1'b1) rd_q <= ram[externalIndexA];
    end

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_UADDR = 3, P_UVAL = 4;
    int          m_phase = P_IDLE;
    int          m_idx   = 0;
    int          m_tick  = 0;
    bit          m_done  = 1'b0;
    int          m_perf  = 0;
    logic [15:0] ref_data [0:1023];
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE; m_idx = 0; m_tick = 0; m_done = 1'b0; m_perf = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_phase != P_IDLE && m_perf < 65535) m_perf++;
            case (m_phase)
                P_IDLE: if (bus.start) begin
                    m_phase = P_LOAD; m_idx = 0; m_perf = 0; exp_q.delete();
                end
                P_LOAD: if (bus.in_valid) begin
                    ref_data[m_idx] = in_data;
                    if (m_idx == 1023) begin
                        m_phase = P_COMP; m_tick = 0; m_idx = 0;
                        for (int k = 0; k < 1024; k++) exp_q.push_back(ref_data[tb_bitrev(k)]);
                    end else m_idx++;
                end
                P_COMP: if (m_tick == 10 * 512 - 1) begin
                    m_phase = P_UADDR; m_idx = 0; m_tick = 0;
                end else m_tick++;
                P_UADDR: m_phase = P_UVAL;
                P_UVAL: if (bus.out_ready) begin
                    if (m_idx == 1023) begin
                        m_phase = P_IDLE; m_idx = 0; m_done = 1'b1;
                    end else begin
                        m_idx++; m_phase = P_UADDR;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    function automatic logic [40:0] model_vec();
        bit ir, ov, el, ld, sc, bs;
        int oi, ex, st, cy;
        ir = (m_phase == P_LOAD);
        ov = (m_phase == P_UVAL);
        sc = (m_phase == P_UADDR) || (m_phase == P_UVAL);
        ld = (m_phase == P_COMP);
        el = ir && (bus.in_valid === 1'b1);
        bs = (m_phase != P_IDLE);
        oi = sc ? m_idx : 0;
        ex = ir ? m_idx : (sc ? tb_bitrev(m_idx) : 0);
        st = ld ? m_tick / 512 : 0;
        cy = ld ? m_tick % 512 : 0;
        return {ir, ov, 10'(oi), el, ld, sc, 10'(ex), 5'(st), 9'(cy), bs, m_done};
    endfunction

    // ---------------- compare process + monitors ----------------
    int          n_load_cyc, n_inrdy_cyc, n_done, nz_cnt, nz_idx;
    logic [9:0]  addr_q[$];
    logic [15:0] exp_d;
    logic [40:0] act_vec;

    always @(negedge clk) begin
        if (chk_en) begin
            act_vec = {bus.in_ready, bus.out_valid, bus.out_index, externalLoad, load, scan,
                       externalIndexA, stageCount, cycleCount, busy, done};
            check("outputs", 64'(act_vec), 64'(model_vec()));
            check("exclusive", 64'($countones({load, externalLoad, scan}) > 1), 64'(0));
            check("state_idle", 64'(dbg_state == ST_IDLE), 64'(m_phase == P_IDLE));
`ifdef FFT_CTRL_PERF_EN
            check("perf", 64'(perfCycles), 64'(m_perf));
`endif
            if (m_phase == P_UVAL && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) check("data_underflow", 64'(1), 64'(0));
                else begin
                    exp_d = exp_q.pop_front();
                    check("data", 64'(rd_q), 64'(exp_d));
                    if (rd_q != 16'd0) begin nz_cnt++; nz_idx = int'(bus.out_index); end
                end
            end
            if (load === 1'b1) n_load_cyc++;
            if (bus.in_ready === 1'b1) n_inrdy_cyc++;
            if (done === 1'b1) n_done++;
            if (scan === 1'b1 && bus.out_valid === 1'b0) addr_q.push_back(externalIndexA);
        end
    end

    // ---------------- driver tasks ----------------
    int hold_cnt;

    task automatic clr_counts();
        n_load_cyc = 0; n_inrdy_cyc = 0; n_done = 0; nz_cnt = 0; nz_idx = -1;
        hold_cnt = 0; addr_q.delete();
    endtask

    task automatic drive(input int mode, input int c);
        case (mode)
            0: begin bus.in_valid = 1'b1; bus.out_ready = 1'b1; in_data = 16'($urandom); end
            1: begin
                bus.in_valid = (c % 2 == 1);
                in_data = 16'($urandom);
                if (bus.out_valid && bus.out_index == 10'd7 && hold_cnt < 5) begin
                    bus.out_ready = 1'b0; hold_cnt++;
                end else bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin bus.in_valid = ($urandom_range(0, 1) == 1); bus.out_ready = 1'b1; in_data = 16'($urandom); end
            default: begin bus.in_valid = 1'b1; bus.out_ready = 1'b1; in_data = 16'd0; end
        endcase
        // Spurious start pulses while busy must be ignored.
        bus.start = busy && ($urandom_range(0, 7) == 0);
    endtask

    task automatic kick(input bit impulse);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        in_data = impulse ? 16'd1 : 16'($urandom);
    endtask

    task automatic xfer(input int mode, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
            else drive(mode, c);
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("done_seen", 64'(seen), 64'(1));
`ifdef FFT_CTRL_PERF_EN
        if (mode == 0 || mode == 3) check("perf_8192", 64'(perfCycles), 64'(8192));
`endif
        @(negedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit hit;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; in_data = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs", 64'({bus.in_ready, bus.out_valid, bus.out_index, externalLoad, load,
              scan, externalIndexA, stageCount, cycleCount, busy, done}), 64'(0));
        rst = 1'b0;

        // Run 0: streaming input and output.
        clr_counts();
        kick(1'b0);
        xfer(0, 20000);
        check("inrdy_cycles", 64'(n_inrdy_cyc), 64'(1024));
        check("load_cycles", 64'(n_load_cyc), 64'(5120));
        check("done_pulses", 64'(n_done), 64'(1));
        check("addr_count", 64'(addr_q.size()), 64'(1024));
        if (addr_q.size() >= 4) begin
            check("addr0", 64'(addr_q[0]), 64'(0));
            check("addr1", 64'(addr_q[1]), 64'(512));
            check("addr2", 64'(addr_q[2]), 64'(256));
            check("addr3", 64'(addr_q[3]), 64'(768));
        end

        // Run 1: gappy input, consumer stall at bin 7 plus random backpressure.
        clr_counts();
        kick(1'b0);
        xfer(1, 30000);
        check("stall_applied", 64'(hold_cnt), 64'(5));
        check("done_pulses_r1", 64'(n_done), 64'(1));
        check("addr_count_r1", 64'(addr_q.size()), 64'(1024));

        // Run 2: reset in the middle of compute.
        clr_counts();
        kick(1'b0);
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(posedge clk); #1;
            if (stageCount == 5'd4 && cycleCount == 9'd100) hit = 1'b1;
            else drive(2, c);
        end
        check("abort_point", 64'(hit), 64'(1));
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done), 64'(0));

        // Run 3: impulse at index 0, fresh start after the abort.
        clr_counts();
        kick(1'b1);
        xfer(3, 20000);
        check("impulse_count", 64'(nz_cnt), 64'(1));
        check("impulse_bin", 64'(nz_idx), 64'(0));
        check("done_pulses_r3", 64'(n_done), 64'(1));

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
